// File: rtl/oka_pkg.sv
// oka_pkg: shared widths, FSM states and split/recombine/reduce helpers for the OKA multiplier.
// OKA_SEQ_REDUCE_EN selects the reduced (N-bit) result build.
package oka_pkg;
    localparam int N_DEF = 283;
    localparam int H_DEF = (N_DEF + 1) / 2;
    localparam int MAX_N = 576;
    localparam int MAX_H = MAX_N / 2;
    localparam int MAX_P = 2 * MAX_H - 1;
    localparam logic [282:0] B283_POLY = 283'h10A1;
`ifdef OKA_SEQ_REDUCE_EN
    localparam bit REDUCE = 1'b1;
`else
    localparam bit REDUCE = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, M0, M1, M2, CMB, RED, OUT} state_e;
    typedef struct packed {
        logic [MAX_H-1:0] even;
        logic [MAX_H-1:0] odd;
    } halves_t;
    function automatic halves_t split(input logic [MAX_N-1:0] v);
        halves_t s;
        for (int i = 0; i < MAX_H; i++) begin
            s.even[i] = v[2*i];
            s.odd[i] = v[2*i+1];
        end
        return s;
    endfunction
    // Overlap-free recombination: even result bits come from pe/po, odd bits from the middle term.
    function automatic logic [2*MAX_N-1:0] recombine(input logic [MAX_P-1:0] pe, po, pm);
        logic [MAX_P-1:0] t;
        logic [2*MAX_N-1:0] r;
        t = pm ^ pe ^ po;
        r = '0;
        r[0] = pe[0];
        r[1] = t[0];
        for (int i = 1; i < MAX_P; i++) begin
            r[2*i] = pe[i] ^ po[i-1];
            r[2*i+1] = t[i];
        end
        r[2*MAX_P] = po[MAX_P-1];
        return r;
    endfunction
    function automatic logic [MAX_N-1:0] reduce(input logic [2*MAX_N-1:0] r, input logic [MAX_N-1:0] poly, input int n);
        logic [2*MAX_N-1:0] m;
        m = (2*MAX_N)'(poly);
        m[n] = 1'b1;
        for (int i = 2*MAX_N-2; i >= 0; i--)
            if (i >= n && r[i]) r = r ^ (m << (i - n));
        return r[MAX_N-1:0];
    endfunction
endpackage

// File: rtl/oka_seq_mult_if.sv
// oka_seq_mult_if: operand/result ready-valid bundle; y narrows to N bits with OKA_SEQ_REDUCE_EN.
interface oka_seq_mult_if #(parameter int N = oka_pkg::N_DEF);
    localparam int YW = oka_pkg::REDUCE ? N : 2 * N - 1;
    logic in_valid;
    logic in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic out_valid;
    logic out_ready;
    logic [YW-1:0] y;
    logic busy;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, y, busy);
    modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, y, busy);
endinterface

// File: rtl/oka_half_mult.sv
// oka_half_mult: combinational H x H carry-less GF(2) multiplier.
module oka_half_mult #(parameter int H = oka_pkg::H_DEF) (
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    output logic [2*H-2:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < H; i++)
            p = p ^ ({(2*H-1){y[i]}} & ((2*H-1)'(x) << i));
    end
endmodule

// File: rtl/oka_seq_mult.sv
// oka_seq_mult: three-cycle overlap-free Karatsuba GF(2)[x] multiplier on one shared half-width core.
// OKA_SEQ_REDUCE_EN adds a RED state folding the product modulo x^N + POLY.
module oka_seq_mult
    import oka_pkg::*;
#(
    parameter int N = N_DEF,
    parameter logic [N-1:0] POLY = N'(B283_POLY)
) (
    input logic clk,
    input logic rst,
    oka_seq_mult_if.slave bus
);
    localparam int H = (N + 1) / 2;
    localparam int P = 2 * H - 1;
    localparam int YW = REDUCE ? N : 2 * N - 1;
    state_e state_q, state_d;
    logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [H-1:0] ae_q, ae_d, ao_q, ao_d, be_q, be_d, bo_q, bo_d;
    logic [P-1:0] pe_q, pe_d, po_q, po_d, pm_q, pm_d;
    logic [YW-1:0] y_q, y_d;
    logic [H-1:0] op_x, op_y;
    logic [P-1:0] prod;
    halves_t sa, sb;
    logic [2*MAX_N-1:0] r_full;
    logic [2*N-2:0] r;
    logic unused_bits;
`ifdef OKA_SEQ_REDUCE_EN
    logic [2*N-2:0] r_q, r_d;
    logic [MAX_N-1:0] red_full;
    assign red_full = reduce((2*MAX_N)'(r_q), MAX_N'(POLY), N);
    assign unused_bits = ^{sa, sb, r_full, red_full};
`else
    assign unused_bits = ^{sa, sb, r_full, POLY};
`endif
    assign sa = split(MAX_N'(bus.a));
    assign sb = split(MAX_N'(bus.b));
    assign r_full = recombine(MAX_P'(pe_q), MAX_P'(po_q), MAX_P'(pm_q));
    assign r = r_full[2*N-2:0];
    // The single core is steered to (ae,be), (ao,bo) or the Karatsuba sums depending on the step.
    assign op_x = state_q == M0 ? ae_q : state_q == M1 ? ao_q : ae_q ^ ao_q;
    assign op_y = state_q == M0 ? be_q : state_q == M1 ? bo_q : be_q ^ bo_q;
    oka_half_mult #(.H(H)) u_core (.x(op_x), .y(op_y), .p(prod));
    always_comb begin
        state_d = state_q;
        ae_d = ae_q;
        ao_d = ao_q;
        be_d = be_q;
        bo_d = bo_q;
        pe_d = pe_q;
        po_d = po_q;
        pm_d = pm_q;
        y_d = y_q;
`ifdef OKA_SEQ_REDUCE_EN
        r_d = r_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid && in_ready_q) begin
                state_d = M0;
                ae_d = sa.even[H-1:0];
                ao_d = sa.odd[H-1:0];
                be_d = sb.even[H-1:0];
                bo_d = sb.odd[H-1:0];
            end
            M0: begin
                pe_d = prod;
                state_d = M1;
            end
            M1: begin
                po_d = prod;
                state_d = M2;
            end
            M2: begin
                pm_d = prod;
                state_d = CMB;
            end
`ifdef OKA_SEQ_REDUCE_EN
            CMB: begin
                r_d = r;
                state_d = RED;
            end
            RED: begin
                y_d = red_full[N-1:0];
                state_d = OUT;
            end
`else
            CMB: begin
                y_d = r;
                state_d = OUT;
            end
`endif
            OUT: state_d = bus.out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
        in_ready_d = state_d == IDLE;
        out_valid_d = state_d == OUT;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            in_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q <= 1'b0;
            ae_q <= '0;
            ao_q <= '0;
            be_q <= '0;
            bo_q <= '0;
            pe_q <= '0;
            po_q <= '0;
            pm_q <= '0;
            y_q <= '0;
`ifdef OKA_SEQ_REDUCE_EN
            r_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q <= busy_d;
            ae_q <= ae_d;
            ao_q <= ao_d;
            be_q <= be_d;
            bo_q <= bo_d;
            pe_q <= pe_d;
            po_q <= po_d;
            pm_q <= pm_d;
            y_q <= y_d;
`ifdef OKA_SEQ_REDUCE_EN
            r_q <= r_d;
`endif
        end
    end
    assign bus.in_ready = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy = busy_q;
    assign bus.y = y_q;
    // A true product of two N-bit polynomials never reaches degree 2N-1.
    a_no_high_terms: assert property (@(posedge clk) disable iff (rst)
        state_q == CMB |-> r_full[2*MAX_N-1:2*N-1] == '0);
endmodule

// File: tb/tb_oka_seq_mult.sv
// tb_oka_seq_mult: directed and random checks of oka_seq_mult against a schoolbook GF(2) model.
module tb_oka_seq_mult;
    import oka_pkg::*;
    localparam int N = 9;
    localparam logic [N-1:0] POLY = N'(B283_POLY);
    localparam int YW = REDUCE ? N : 2 * N - 1;
    localparam int LAT = REDUCE ? 6 : 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    oka_seq_mult_if #(.N(N)) bus ();
    oka_seq_mult #(.N(N), .POLY(POLY)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [YW-1:0] model(input logic [N-1:0] x, input logic [N-1:0] z);
        logic [2*N-2:0] p;
        p = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                p[i+j] = p[i+j] ^ (x[i] & z[j]);
        if (REDUCE)
            for (int k = 2*N-2; k >= N; k--)
                if (p[k]) begin
                    p[k] = 1'b0;
                    for (int j = 0; j < N; j++) p[k-N+j] = p[k-N+j] ^ POLY[j];
                end
        return p[YW-1:0];
    endfunction
    task automatic chk(input string tag, input logic [YW-1:0] obs, input logic [YW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chkb("ready_wait", bus.in_ready, 1'b1);
    endtask
    task automatic op(input logic [N-1:0] x, input logic [N-1:0] z, input logic [YW-1:0] exp, input int stall);
        wait_ready();
        bus.a = x;
        bus.b = z;
        bus.in_valid = 1'b1;
        bus.out_ready = stall == 0;
        tick();
        bus.in_valid = 1'b0;
        bus.a = N'($urandom);
        bus.b = N'($urandom);
        for (int e = 1; e < LAT; e++) begin
            chkb("early_valid", bus.out_valid, 1'b0);
            chkb("busy_ready", bus.in_ready, 1'b0);
            chkb("busy", bus.busy, 1'b1);
            tick();
        end
        chkb("valid_edge", bus.out_valid, 1'b1);
        chkb("out_ready_low", bus.in_ready, 1'b0);
        chk("y", bus.y, exp);
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'($urandom);
            bus.a = N'($urandom);
            bus.b = N'($urandom);
            tick();
            chkb("stall_valid", bus.out_valid, 1'b1);
            chk("stall_y", bus.y, exp);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chkb("done_valid", bus.out_valid, 1'b0);
        chkb("done_ready", bus.in_ready, 1'b1);
        chkb("done_busy", bus.busy, 1'b0);
    endtask
    initial begin
        logic [N-1:0] ra, rb;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        repeat (3) tick();
        chkb("rst_ready", bus.in_ready, 1'b1);
        chkb("rst_valid", bus.out_valid, 1'b0);
        chkb("rst_busy", bus.busy, 1'b0);
        chk("rst_y", bus.y, '0);
        rst = 1'b0;
        op(9'h003, 9'h003, REDUCE ? model(9'h003, 9'h003) : YW'(17'h00005), 0);
        op(9'h100, 9'h100, REDUCE ? model(9'h100, 9'h100) : YW'(17'h10000), 0);
        op(9'h1FF, 9'h001, REDUCE ? model(9'h1FF, 9'h001) : YW'(17'h001FF), 0);
        op(9'h0B5, 9'h1C3, model(9'h0B5, 9'h1C3), 20);
        op(9'h000, 9'h1FF, '0, 1);
        op(9'h1FF, 9'h1FF, model(9'h1FF, 9'h1FF), 0);
        wait_ready();
        bus.a = 9'h0B5;
        bus.b = 9'h1C3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chkb("pre_abort_busy", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chkb("abort_valid", bus.out_valid, 1'b0);
        chkb("abort_ready", bus.in_ready, 1'b1);
        chkb("abort_busy", bus.busy, 1'b0);
        chk("abort_y", bus.y, '0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chkb("abort_silent", bus.out_valid, 1'b0);
        end
        op(9'h123, 9'h0F0, model(9'h123, 9'h0F0), 2);
        for (int i = 0; i < 300; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            op(ra, rb, model(ra, rb), int'($urandom_range(0, 3)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
